// File: rtl/pipe_adder_pkg.sv
// Shared helpers for the pipelined adder: chunk sizing and configuration checks.
package pipe_adder_pkg;

    // Width of one carry-chained chunk resolved per pipeline stage.
    function automatic int chunk_w(input int n, input int stages);
        return n / stages;
    endfunction

    // A configuration is legal when the operand splits into equal, non-empty chunks.
    function automatic bit cfg_ok(input int n, input int stages);
        return (stages >= 1) && (n >= stages) && ((n % stages) == 0);
    endfunction

endpackage

// File: rtl/chunk_add.sv
// Combinational W-bit add of one operand chunk with carry in, carry out and carry into the MSB.
module chunk_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    logic [W:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign sum   = total[W-1:0];
    assign cout  = total[W];
    // The MSB sum bit is a^b^carry_in, so the carry into it can be recovered.
    assign cmsb  = a[W-1] ^ b[W-1] ^ total[W-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined N-bit adder/subtractor: one W-bit chunk of the carry chain is resolved per stage,
// with the whole pipe stalling together on output backpressure.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         c_out,
    output logic         ovf
);

    localparam int W = chunk_w(N, STAGES);

    if (!cfg_ok(N, STAGES)) begin : g_cfg_err
        $error("pipe_adder: N=%0d is not a multiple of STAGES=%0d", N, STAGES);
    end

    // sum_lo accumulates resolved chunks in place; a_hi/b_hi are shifted so the
    // next chunk to consume always sits in bits [W-1:0].
    typedef struct packed {
        logic         valid;
        logic [N-1:0] sum_lo;
        logic         carry;
        logic [N-1:0] a_hi;
        logic [N-1:0] b_hi;
    } stage_t;

    stage_t       stage_in  [STAGES];
    stage_t       stage_nxt [STAGES];
    stage_t       stage_q   [STAGES];
    logic [W-1:0] chunk_sum  [STAGES];
    logic         chunk_cout [STAGES];
    logic         chunk_cmsb [STAGES];
    logic         ovf_q;
    logic         adv;

    // Handshake: a beat moves on an edge where valid && ready. Every stage advances
    // together when the output slot is empty or being consumed; in_ready depends only
    // on out_valid/out_ready, never on in_valid.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        stage_in[0].valid  = in_valid;
        stage_in[0].sum_lo = '0;
        stage_in[0].carry  = sub ? 1'b1 : c_in;
        stage_in[0].a_hi   = a;
        stage_in[0].b_hi   = sub ? ~b : b;
        for (int k = 1; k < STAGES; k++) begin
            stage_in[k] = stage_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        chunk_add #(.W(W)) u_chunk (
            .a    (stage_in[k].a_hi[W-1:0]),
            .b    (stage_in[k].b_hi[W-1:0]),
            .cin  (stage_in[k].carry),
            .sum  (chunk_sum[k]),
            .cout (chunk_cout[k]),
            .cmsb (chunk_cmsb[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stage_nxt[k].valid  = stage_in[k].valid;
            stage_nxt[k].sum_lo = stage_in[k].sum_lo | (N'(chunk_sum[k]) << (k * W));
            stage_nxt[k].carry  = chunk_cout[k];
            stage_nxt[k].a_hi   = stage_in[k].a_hi >> W;
            stage_nxt[k].b_hi   = stage_in[k].b_hi >> W;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= stage_nxt[k];
            end
            // Only the top chunk holds the sign bit, so overflow comes from it alone.
            ovf_q <= chunk_cmsb[STAGES-1] ^ chunk_cout[STAGES-1];
        end
    end

    assign out_valid = stage_q[STAGES-1].valid;
    assign s         = stage_q[STAGES-1].sum_lo;
    assign c_out     = stage_q[STAGES-1].carry;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: a main N=8/STAGES=2 instance checked every cycle against
// an arithmetic model, plus N=32/STAGES=4 and N=16/STAGES=1 instances for latency and wrap checks.
module tb_pipe_adder;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    // Main instance, N=8 STAGES=2
    logic       in_valid8, in_ready8, c_in8, sub8, out_valid8, out_ready8, c_out8, ovf8;
    logic [7:0] a8, b8, s8;

    pipe_adder #(.N(8), .STAGES(2)) dut8 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .c_in(c_in8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .s(s8), .c_out(c_out8), .ovf(ovf8)
    );

    // Sweep instance, N=32 STAGES=4
    logic        in_valid32, in_ready32, c_in32, sub32, out_valid32, out_ready32, c_out32, ovf32;
    logic [31:0] a32, b32, s32;

    pipe_adder #(.N(32), .STAGES(4)) dut32 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .c_in(c_in32), .sub(sub32),
        .out_valid(out_valid32), .out_ready(out_ready32),
        .s(s32), .c_out(c_out32), .ovf(ovf32)
    );

    // Sweep instance, N=16 STAGES=1
    logic        in_valid16, in_ready16, c_in16, sub16, out_valid16, out_ready16, c_out16, ovf16;
    logic [15:0] a16, b16, s16;

    pipe_adder #(.N(16), .STAGES(1)) dut16 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .c_in(c_in16), .sub(sub16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .s(s16), .c_out(c_out16), .ovf(ovf16)
    );

    // Scoreboard: {c_out, ovf, s} for every beat accepted by the main instance
    logic [9:0] exp_q[$];
    int         n_checks  = 0;
    int         n_fail    = 0;
    int         n_results = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: integer arithmetic straight from the add/subtract definition.
    function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y,
                                          input logic ci, input logic sb);
        int  ux, uy, sx, sy, full, sres;
        logic carry, of;
        ux = x;
        uy = y;
        sx = $signed(x);
        sy = $signed(y);
        if (sb) begin
            full  = ux - uy;
            sres  = sx - sy;
            carry = (ux >= uy);
        end else begin
            full  = ux + uy + int'(ci);
            sres  = sx + sy + int'(ci);
            carry = (full > 255);
        end
        of = (sres > 127) || (sres < -128);
        return {carry, of, full[7:0]};
    endfunction

    // Compare process: runs every falling edge while out of reset
    logic       stall_seen = 1'b0;
    logic [9:0] held_out   = '0;

    always @(negedge clk) begin
        if (!rstn) begin
            stall_seen = 1'b0;
        end else begin
            check("in_ready_rule", in_ready8, !out_valid8 || out_ready8);
            if (stall_seen)
                check("stall_hold", {out_valid8, c_out8, ovf8, s8}, {1'b1, held_out});
            if (out_valid8 && out_ready8) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: got s=0x%0h with no beat outstanding at %0t", s8, $time);
                end else begin
                    check("result", {c_out8, ovf8, s8}, exp_q.pop_front());
                    n_results++;
                end
            end
            stall_seen = out_valid8 && !out_ready8;
            held_out   = {c_out8, ovf8, s8};
            if (in_valid8 && in_ready8)
                exp_q.push_back(model8(a8, b8, c_in8, sub8));
        end
    end

    // Drivers: called just after a rising edge; return just after the accepting edge
    int last_waits;

    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic ts);
        int guard = 0;
        a8 = ta; b8 = tb; c_in8 = tc; sub8 = ts; in_valid8 = 1'b1;
        do begin
            @(negedge clk);
            guard++;
        end while (!in_ready8 && guard < 100);
        if (!in_ready8) check("send_timeout", in_ready8, 1);
        last_waits = guard;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid8 = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic run32(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                         input logic ts, input logic [33:0] exp, input int exp_lat);
        int lat;
        a32 = ta; b32 = tb; c_in32 = tc; sub32 = ts; in_valid32 = 1'b1;
        @(negedge clk);
        check("w32_in_ready", in_ready32, 1);
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        lat = 1;
        while (!out_valid32 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w32_latency", lat, exp_lat);
        check("w32_result", {c_out32, ovf32, s32}, exp);
        @(posedge clk); #1;
    endtask

    task automatic run16(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                         input logic ts, input logic [17:0] exp, input int exp_lat);
        int lat;
        a16 = ta; b16 = tb; c_in16 = tc; sub16 = ts; in_valid16 = 1'b1;
        @(negedge clk);
        check("w16_in_ready", in_ready16, 1);
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        lat = 1;
        while (!out_valid16 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w16_latency", lat, exp_lat);
        check("w16_result", {c_out16, ovf16, s16}, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        rstn = 1'b0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; c_in8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
        in_valid32 = 1'b0; a32 = '0; b32 = '0; c_in32 = 1'b0; sub32 = 1'b0; out_ready32 = 1'b1;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; c_in16 = 1'b0; sub16 = 1'b0; out_ready16 = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out8", {out_valid8, c_out8, ovf8, s8}, 11'h000);
        check("reset_valid_sweep", {out_valid32, out_valid16}, 2'b00);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Add crossing into the sign bit, exact latency of two edges
        send(8'h7F, 8'h01, 1'b0, 1'b0);
        idle();
        check("t1_not_yet", out_valid8, 0);
        @(posedge clk); #1;
        check("t1_add_ovf", {out_valid8, c_out8, ovf8, s8}, {1'b1, 1'b0, 1'b1, 8'h80});

        // Subtract with borrow (c_in ignored), then subtract overflowing negative
        send(8'h05, 8'h07, 1'b1, 1'b1);
        idle();
        @(posedge clk); #1;
        check("t2_sub_borrow", {out_valid8, c_out8, ovf8, s8}, {1'b1, 1'b0, 1'b0, 8'hFE});
        send(8'h80, 8'h01, 1'b0, 1'b1);
        idle();
        @(posedge clk); #1;
        check("t2_sub_ovf", {out_valid8, c_out8, ovf8, s8}, {1'b1, 1'b1, 1'b1, 8'h7F});
        wait_drain();

        // Back-to-back stream of 16 beats at full throughput
        base = n_results;
        for (int i = 0; i < 16; i++) begin
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check("t3_in_ready_stream", last_waits, 1);
        end
        idle();
        wait_drain();
        check("t3_result_count", n_results - base, 16);

        // Backpressure: fill the pipe, hold for 5 cycles, then release
        base = n_results;
        out_ready8 = 1'b0;
        send(8'h10, 8'h20, 1'b0, 1'b0);
        send(8'h40, 8'h50, 1'b0, 1'b0);
        a8 = 8'hF0; b8 = 8'h20; c_in8 = 1'b0; sub8 = 1'b0; in_valid8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_in_ready_low", in_ready8, 0);
            check("t4_head_held", {out_valid8, c_out8, ovf8, s8}, {1'b1, 1'b0, 1'b0, 8'h30});
        end
        @(posedge clk); #1;
        out_ready8 = 1'b1;
        @(negedge clk);
        check("t4_release_ready", in_ready8, 1);
        @(posedge clk); #1;
        idle();
        wait_drain();
        check("t4_result_count", n_results - base, 3);

        // Asynchronous reset with two beats in flight
        send(8'h11, 8'h22, 1'b0, 1'b0);
        send(8'h33, 8'h44, 1'b0, 1'b0);
        idle();
        #1 rstn = 1'b0;
        #1;
        check("t5_reset_flush", {out_valid8, c_out8, ovf8, s8}, 11'h000);
        exp_q.delete();
        base = n_results;
        #9 rstn = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            check("t5_no_stale", out_valid8, 0);
            @(posedge clk); #1;
        end
        check("t5_no_results", n_results - base, 0);
        send(8'h01, 8'h01, 1'b1, 1'b0);
        idle();
        @(posedge clk); #1;
        check("t5_after_reset", {out_valid8, c_out8, ovf8, s8}, {1'b1, 1'b0, 1'b0, 8'h03});
        wait_drain();

        // Configuration sweep: N=32 STAGES=4 and N=16 STAGES=1
        run32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h0000_0000}, 4);
        run32(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, {1'b0, 1'b1, 32'h8000_0000}, 4);
        run32(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b0, 32'h0001_0000}, 4);
        run32(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFF}, 4);
        run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000}, 1);
        run16(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, {1'b1, 1'b0, 16'hFFFF}, 1);
        run16(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF}, 1);

        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
